tail_light_decoder: RTL and testbench

Monitors the six tail-lamp lines produced by the turn-signal sequencer and decodes them back into direction, sweep progress and fault status. Sits at the lamp-driver boundary as the receiving end of the lamp pattern interface. It feeds the dashboard indicator logic and the self-test/diagnostic path. Samples asynchronous lamp lines, tracks the legal sweep sequence, counts completed sweeps per side and flags illegal patterns or transitions.

---
 rtl/tail_light_pkg.sv | 72 +++++++
 rtl/sync_2ff.sv | 26 ++
 rtl/tail_light_decoder.sv | 178 +++++++++++++++++
 tb/tb_tail_light_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// Shared state encoding and lamp pattern constants for the tail-light decoder.
// State codes match the sequencer's 3-bit encoding so both ends agree on the bus.
package tail_light_pkg;

  localparam logic [2:0] StIdle = 3'b000;
  localparam logic [2:0] StL1   = 3'b001;
  localparam logic [2:0] StL2   = 3'b011;
  localparam logic [2:0] StL3   = 3'b010;
  localparam logic [2:0] StR1   = 3'b110;
  localparam logic [2:0] StR2   = 3'b111;
  localparam logic [2:0] StR3   = 3'b101;
  localparam logic [2:0] StErr  = 3'b100;

  // Bit order is {lc, lb, la, rc, rb, ra}.
  localparam logic [5:0] PatOff = 6'b000_000;
  localparam logic [5:0] PatL1  = 6'b001_000;
  localparam logic [5:0] PatL2  = 6'b011_000;
  localparam logic [5:0] PatL3  = 6'b111_000;
  localparam logic [5:0] PatR1  = 6'b000_001;
  localparam logic [5:0] PatR2  = 6'b000_011;
  localparam logic [5:0] PatR3  = 6'b000_111;

  function automatic logic [5:0] state_pattern(input logic [2:0] st);
    logic [5:0] pat;
    pat = PatOff;
    case (st)
      StL1:    pat = PatL1;
      StL2:    pat = PatL2;
      StL3:    pat = PatL3;
      StR1:    pat = PatR1;
      StR2:    pat = PatR2;
      StR3:    pat = PatR3;
      default: pat = PatOff;
    endcase
    return pat;
  endfunction

  // StErr here means "no further step on this side".
  function automatic logic [2:0] next_state(input logic [2:0] st);
    logic [2:0] nxt;
    nxt = StErr;
    case (st)
      StL1:    nxt = StL2;
      StL2:    nxt = StL3;
      StR1:    nxt = StR2;
      StR2:    nxt = StR3;
      default: nxt = StErr;
    endcase
    return nxt;
  endfunction

  function automatic logic is_left(input logic [2:0] st);
    return (st == StL1) || (st == StL2) || (st == StL3);
  endfunction

  function automatic logic is_right(input logic [2:0] st);
    return (st == StR1) || (st == StR2) || (st == StR3);
  endfunction

  function automatic logic [1:0] step_of(input logic [2:0] st);
    logic [1:0] s;
    s = 2'd0;
    case (st)
      StL1, StR1: s = 2'd1;
      StL2, StR2: s = 2'd2;
      StL3, StR3: s = 2'd3;
      default:    s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/tail_light_decoder.sv
// Decodes the six tail-lamp lines into sweep direction/step, sweep counts and faults.
// Optional hold timeout compiled in with `define TAIL_DEC_TIMEOUT_EN.
module tail_light_decoder
  import tail_light_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             la,
  input  logic             lb,
  input  logic             lc,
  input  logic             ra,
  input  logic             rb,
  input  logic             rc,
  input  logic             clr,
  output logic             left_active,
  output logic             right_active,
  output logic [1:0]       step,
  output logic             sweep_done,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic             err,
  output logic             err_sticky
);

  if (CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("tail_light_decoder: CNT_W and TIMEOUT_CYCLES must be non-zero");
  end

  logic [5:0] lamp_raw;
  logic [5:0] pat;

  assign lamp_raw = {lc, lb, la, rc, rb, ra};

  sync_2ff #(
    .WIDTH (6)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lamp_raw),
    .q     (pat)
  );

  logic [2:0] state_q, state_d;
  logic       active;
  logic       timeout;

  assign active = is_left(state_q) || is_right(state_q);

`ifdef TAIL_DEC_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(TIMEOUT_CYCLES + 1);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  assign timeout = active && (hold_cnt_q >= HoldW'(TIMEOUT_CYCLES));

  always_comb begin
    hold_cnt_d = '0;
    if (active && (state_d == state_q)) begin
      hold_cnt_d = hold_cnt_q + HoldW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (pat == PatL1) begin
          state_d = StL1;
        end else if (pat == PatR1) begin
          state_d = StR1;
        end else if (pat != PatOff) begin
          state_d = StErr;
        end
      end
      StErr: begin
        if (pat == PatOff) begin
          state_d = StIdle;
        end
      end
      default: begin
        if (pat == state_pattern(state_q)) begin
          state_d = state_q;
        end else if (pat == PatOff) begin
          state_d = StIdle;
        end else if ((next_state(state_q) != StErr) &&
                     (pat == state_pattern(next_state(state_q)))) begin
          state_d = next_state(state_q);
        end else begin
          state_d = StErr;
        end
      end
    endcase
    if (timeout) begin
      state_d = StErr;
    end
  end

  logic left_inc, right_inc, err_enter;

  assign left_inc  = (state_d == StL3) && (state_q != StL3);
  assign right_inc = (state_d == StR3) && (state_q != StR3);
  assign err_enter = (state_d == StErr) && (state_q != StErr);

  logic             left_active_q, right_active_q, sweep_done_q, err_q, err_sticky_q;
  logic [1:0]       step_q;
  logic [CNT_W-1:0] left_cnt_q, right_cnt_q;

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      left_active_q  <= 1'b0;
      right_active_q <= 1'b0;
      step_q         <= 2'd0;
      sweep_done_q   <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      left_active_q  <= is_left(state_d);
      right_active_q <= is_right(state_d);
      step_q         <= step_of(state_d);
      sweep_done_q   <= left_inc || right_inc;
      err_q          <= (state_d == StErr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_cnt_q  <= '0;
      right_cnt_q <= '0;
    end else if (clr) begin
      left_cnt_q  <= '0;
      right_cnt_q <= '0;
    end else begin
      if (left_inc && (left_cnt_q != {CNT_W{1'b1}})) begin
        left_cnt_q <= left_cnt_q + CNT_W'(1);
      end
      if (right_inc && (right_cnt_q != {CNT_W{1'b1}})) begin
        right_cnt_q <= right_cnt_q + CNT_W'(1);
      end
    end
  end

  // A fault arriving together with clr must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else if (err_enter) begin
      err_sticky_q <= 1'b1;
    end else if (clr) begin
      err_sticky_q <= 1'b0;
    end
  end

  assign left_active  = left_active_q;
  assign right_active = right_active_q;
  assign step         = step_q;
  assign sweep_done   = sweep_done_q;
  assign left_cnt     = left_cnt_q;
  assign right_cnt    = right_cnt_q;
  assign err          = err_q;
  assign err_sticky   = err_sticky_q;

endmodule

// File: tb/tb_tail_light_decoder.sv
// Scoreboard bench for tail_light_decoder: stimulus pushes model predictions,
// a monitor pops and compares one prediction per clock.
module tb_tail_light_decoder;

  localparam int unsigned CntW = 8;
`ifdef TAIL_DEC_TIMEOUT_EN
  localparam int unsigned ToCycles = 20;
`else
  localparam int unsigned ToCycles = 100_000_000;
`endif
  localparam int CntMax = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic la = 1'b0, lb = 1'b0, lc = 1'b0, ra = 1'b0, rb = 1'b0, rc = 1'b0;
  logic clr = 1'b0;
  logic            left_active, right_active, sweep_done, err, err_sticky;
  logic [1:0]      step;
  logic [CntW-1:0] left_cnt, right_cnt;

  always #5 clk = ~clk;

  tail_light_decoder #(
    .CNT_W          (CntW),
    .TIMEOUT_CYCLES (ToCycles)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .la           (la),
    .lb           (lb),
    .lc           (lc),
    .ra           (ra),
    .rb           (rb),
    .rc           (rc),
    .clr          (clr),
    .left_active  (left_active),
    .right_active (right_active),
    .step         (step),
    .sweep_done   (sweep_done),
    .left_cnt     (left_cnt),
    .right_cnt    (right_cnt),
    .err          (err),
    .err_sticky   (err_sticky)
  );

  typedef struct {
    int left_active;
    int right_active;
    int step;
    int sweep_done;
    int left_cnt;
    int right_cnt;
    int err;
    int err_sticky;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: side 0 none / 1 left / 2 right, lvl = lamps lit.
  int m_side, m_lvl, m_err, m_sticky, m_lcnt, m_rcnt, m_hold;
  logic [5:0] m_d1, m_d2;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_side = 0; m_lvl = 0; m_err = 0; m_sticky = 0;
    m_lcnt = 0; m_rcnt = 0; m_hold = 0;
    m_d1 = '0; m_d2 = '0;
  endfunction

  function automatic int ones3(input logic [2:0] b);
    return int'(b[0]) + int'(b[1]) + int'(b[2]);
  endfunction

  function automatic bit ramp(input logic [2:0] b);
    return (b == 3'b000) || (b == 3'b001) || (b == 3'b011) || (b == 3'b111);
  endfunction

  function automatic exp_t model_step(input logic [5:0] p, input bit c);
    logic [5:0] seen;
    logic [2:0] l, r;
    bit legal, done;
    int ns, nl, o_err, o_lvl, o_side;
    exp_t e;
    seen = m_d2; m_d2 = m_d1; m_d1 = p;
    l = seen[5:3]; r = seen[2:0];
    legal = ((l == 3'b0) || (r == 3'b0)) && ramp(l) && ramp(r);
    ns = (l != 3'b0) ? 1 : ((r != 3'b0) ? 2 : 0);
    nl = ones3(l) + ones3(r);
    o_err = m_err; o_lvl = m_lvl; o_side = m_side;
    if (m_err != 0) begin
      if (legal && nl == 0) m_err = 0;
    end else if (m_lvl == 0) begin
      if (!legal || nl > 1) m_err = 1;
      else begin m_lvl = nl; m_side = ns; end
    end else if (m_hold >= int'(ToCycles) || !legal) begin
      m_err = 1;
    end else if (nl == 0) begin
      m_lvl = 0; m_side = 0;
    end else if (ns == m_side && (nl == m_lvl || nl == m_lvl + 1)) begin
      m_lvl = nl;
    end else begin
      m_err = 1;
    end
    if (m_err != 0) begin m_lvl = 0; m_side = 0; end
    if (m_err == 0 && m_lvl > 0 && o_err == 0 && m_lvl == o_lvl && m_side == o_side)
      m_hold = m_hold + 1;
    else
      m_hold = 0;
    done = (m_err == 0) && (m_lvl == 3) && (o_lvl != 3);
    if (c) begin
      m_lcnt = 0; m_rcnt = 0;
    end else if (done) begin
      if (m_side == 1 && m_lcnt < CntMax) m_lcnt++;
      if (m_side == 2 && m_rcnt < CntMax) m_rcnt++;
    end
    if (m_err != 0 && o_err == 0) m_sticky = 1;
    else if (c) m_sticky = 0;
    e.left_active  = (m_side == 1) ? 1 : 0;
    e.right_active = (m_side == 2) ? 1 : 0;
    e.step         = m_lvl;
    e.sweep_done   = done ? 1 : 0;
    e.left_cnt     = m_lcnt;
    e.right_cnt    = m_rcnt;
    e.err          = m_err;
    e.err_sticky   = m_sticky;
    return e;
  endfunction

  function automatic logic [5:0] mk(input int side, input int lvl);
    logic [2:0] b;
    b = 3'((1 << lvl) - 1);
    return (side == 1) ? {b, 3'b000} : {3'b000, b};
  endfunction

  task automatic drive(input logic [5:0] p, input bit c);
    @(negedge clk);
    {lc, lb, la, rc, rb, ra} = p;
    clr = c;
    sb_q.push_back(model_step(p, c));
  endtask

  task automatic drive_n(input logic [5:0] p, input int n);
    for (int i = 0; i < n; i++) drive(p, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".left_active"}, int'(left_active), 0);
    check({tag, ".right_active"}, int'(right_active), 0);
    check({tag, ".step"}, int'(step), 0);
    check({tag, ".sweep_done"}, int'(sweep_done), 0);
    check({tag, ".left_cnt"}, int'(left_cnt), 0);
    check({tag, ".right_cnt"}, int'(right_cnt), 0);
    check({tag, ".err"}, int'(err), 0);
    check({tag, ".err_sticky"}, int'(err_sticky), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("left_active", int'(left_active), e.left_active);
        check("right_active", int'(right_active), e.right_active);
        check("step", int'(step), e.step);
        check("sweep_done", int'(sweep_done), e.sweep_done);
        check("left_cnt", int'(left_cnt), e.left_cnt);
        check("right_cnt", int'(right_cnt), e.right_cnt);
        check("err", int'(err), e.err);
        check("err_sticky", int'(err_sticky), e.err_sticky);
      end
    end
  end

  initial begin : stimulus
    int side, lvl, r, n;
    logic [5:0] p;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Full left sweep, 10 cycles per step.
    drive_n(mk(1, 1), 10);
    drive_n(mk(1, 2), 10);
    drive_n(mk(1, 3), 10);
    drive_n(6'b0, 10);

    // Right sweep skipping R2, then recovery and sticky clear.
    drive_n(mk(2, 1), 5);
    drive_n(mk(2, 3), 5);
    drive_n(6'b0, 5);
    drive(6'b0, 1'b1);
    drive_n(6'b0, 3);

    // Both sides lit from idle.
    drive_n(6'b001_001, 5);
    drive_n(6'b0, 4);

    // Saturate the left counter.
    for (int i = 0; i < 300; i++) begin
      drive(mk(1, 1), 1'b0);
      drive(mk(1, 2), 1'b0);
      drive(mk(1, 3), 1'b0);
      drive(6'b0, 1'b0);
    end
    drive_n(6'b0, 2);

    // Clear on the same edge the sweep reaches step 3.
    drive(mk(1, 1), 1'b0);
    drive(mk(1, 2), 1'b0);
    drive(mk(1, 3), 1'b0);
    drive(6'b0, 1'b0);
    drive(6'b0, 1'b1);
    drive_n(6'b0, 3);

    // Long R1 hold.
    drive_n(mk(2, 1), 25);
    drive_n(6'b0, 4);

    // Asynchronous reset while in L2, released with L2 still lit.
    drive_n(mk(1, 1), 3);
    drive_n(mk(1, 2), 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive_n(mk(1, 2), 5);
    drive_n(6'b0, 4);

    // Randomized walk biased toward legal sweeps.
    side = 0; lvl = 0;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 15));
      p = mk(side, lvl);
      if (r <= 7) begin
        if (lvl == 0) begin side = int'($urandom_range(1, 2)); lvl = 1; end
        else if (lvl < 3) lvl++;
        else lvl = 0;
        p = mk(side, lvl);
      end else if (r <= 10) begin
        lvl = 0;
        p = 6'b0;
      end else if (r <= 12) begin
        side = int'($urandom_range(1, 2));
        lvl = int'($urandom_range(0, 3));
        p = mk(side, lvl);
      end else if (r == 13) begin
        p = 6'($urandom);
      end
      n = int'($urandom_range(1, 3));
      drive(p, $urandom_range(0, 31) == 0);
      drive_n(p, n - 1);
    end
    drive_n(6'b0, 4);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
